// File: rtl/multiport_ram_if.sv
// Bus bundle for multiport_ram: one write port plus NUM_RD packed read ports.
interface multiport_ram_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         i_we;
  logic [XLEN/8-1:0]            i_wBe;
  logic [ADDR_WIDTH-1:0]        i_wAddr;
  logic [XLEN-1:0]              i_dataIn;
  logic [NUM_RD-1:0]            i_rEn;
  logic [NUM_RD*ADDR_WIDTH-1:0] i_rAddr;
  logic [NUM_RD*XLEN-1:0]       o_q;
  logic [NUM_RD-1:0]            o_valid;

  modport master (
    output i_we, i_wBe, i_wAddr, i_dataIn, i_rEn, i_rAddr,
    input  o_q, o_valid
  );

  modport slave (
    input  i_we, i_wBe, i_wAddr, i_dataIn, i_rEn, i_rAddr,
    output o_q, o_valid
  );
endinterface

// File: rtl/multiport_ram.sv
// Parametrised RAM: one byte-enabled synchronous write port, NUM_RD synchronous
// read ports with selectable read-during-write bypass, optional output stage
// and optional hard-wired zero at address 0 (register-file use).
module multiport_ram #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int RDW_MODE   = 1,
  parameter int OUT_REG    = 0,
  parameter int R0_ZERO    = 0
) (
  input logic            i_clk,
  input logic            i_rst,
  multiport_ram_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = XLEN / 8;

  // Storage starts all-zero and is deliberately untouched by reset.
  logic [XLEN-1:0]          mem_q [DEPTH] = '{default: '0};
  logic                     writeEn;
  logic [NUM_RD*XLEN-1:0]   rdData_d;
  logic [NUM_RD*XLEN-1:0]   q_q;
  logic [NUM_RD-1:0]        valid_q;
  logic [ADDR_WIDTH-1:0]    rdAddr;
  logic [XLEN-1:0]          rdWord;

  // A write only lands when out of reset and not aimed at a hard-wired zero entry.
  assign writeEn = bus.i_we && !i_rst &&
                   !((R0_ZERO != 0) && (bus.i_wAddr == '0));

  // Byte-lane write into the array; lanes with a clear enable keep their contents.
  always_ff @(posedge i_clk) begin
    if (writeEn) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (bus.i_wBe[k]) begin
          mem_q[bus.i_wAddr][8*k +: 8] <= bus.i_dataIn[8*k +: 8];
        end
      end
    end
  end

  // Per-port read data: array word, optionally byte-merged with a same-address
  // write this edge, then forced to zero for address 0 when R0_ZERO is set.
  always_comb begin
    rdData_d = '0;
    rdAddr   = '0;
    rdWord   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdAddr = bus.i_rAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rdWord = mem_q[rdAddr];
      if ((RDW_MODE != 0) && writeEn && (rdAddr == bus.i_wAddr)) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (bus.i_wBe[k]) begin
            rdWord[8*k +: 8] = bus.i_dataIn[8*k +: 8];
          end
        end
      end
      if ((R0_ZERO != 0) && (rdAddr == '0)) begin
        rdWord = '0;
      end
      rdData_d[p*XLEN +: XLEN] = rdWord;
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic [NUM_RD*XLEN-1:0] s1Data_q;
    logic [NUM_RD-1:0]      s1Valid_q;

    // Two-stage read path: capture into stage 1, then present on the outputs;
    // an output lane only updates when the stage-1 entry carries a real read.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1Data_q  <= '0;
        s1Valid_q <= '0;
        q_q       <= '0;
        valid_q   <= '0;
      end else begin
        s1Data_q  <= rdData_d;
        s1Valid_q <= bus.i_rEn;
        valid_q   <= s1Valid_q;
        for (int p = 0; p < NUM_RD; p++) begin
          if (s1Valid_q[p]) begin
            q_q[p*XLEN +: XLEN] <= s1Data_q[p*XLEN +: XLEN];
          end
        end
      end
    end
  end else begin : g_noOutReg
    // Single-stage read path: enabled lanes load, idle lanes hold their last value.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q_q     <= '0;
        valid_q <= '0;
      end else begin
        valid_q <= bus.i_rEn;
        for (int p = 0; p < NUM_RD; p++) begin
          if (bus.i_rEn[p]) begin
            q_q[p*XLEN +: XLEN] <= rdData_d[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign bus.o_q     = q_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_multiport_ram.sv
// Bench for multiport_ram: three 2-port variants (new-data bypass, old-data,
// zero-register) share one vector table; a 3-port pipelined variant gets
// hand-written sequences. Expected values flow through a due-cycle scoreboard.
module tb_multiport_ram;

  logic clk = 1'b0;
  logic rstAbc;
  logic rstD;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  multiport_ram_if #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifA ();
  multiport_ram_if #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifB ();
  multiport_ram_if #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifC ();
  multiport_ram_if #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(3)) ifD ();

  multiport_ram #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2), .RDW_MODE(1), .OUT_REG(0), .R0_ZERO(0))
    dutA (.i_clk(clk), .i_rst(rstAbc), .bus(ifA.slave));
  multiport_ram #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2), .RDW_MODE(0), .OUT_REG(0), .R0_ZERO(0))
    dutB (.i_clk(clk), .i_rst(rstAbc), .bus(ifB.slave));
  multiport_ram #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2), .RDW_MODE(1), .OUT_REG(0), .R0_ZERO(1))
    dutC (.i_clk(clk), .i_rst(rstAbc), .bus(ifC.slave));
  multiport_ram #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(3), .RDW_MODE(1), .OUT_REG(1), .R0_ZERO(0))
    dutD (.i_clk(clk), .i_rst(rstD), .bus(ifD.slave));

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  vld;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  vec_t  vecs [15];
  chk_t  sbq [$];
  int    cycle   = 0;
  int    nChecks = 0;
  int    nFails  = 0;
  string selName [10] = '{"A.q0", "A.q1", "A.valid", "B.q0", "C.q0", "C.q1",
                          "D.q0", "D.q1", "D.q2", "D.valid"};

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return ifA.o_q[31:0];
      1:       return ifA.o_q[63:32];
      2:       return {30'b0, ifA.o_valid};
      3:       return ifB.o_q[31:0];
      4:       return ifC.o_q[31:0];
      5:       return ifC.o_q[63:32];
      6:       return ifD.o_q[31:0];
      7:       return ifD.o_q[63:32];
      8:       return ifD.o_q[95:64];
      9:       return {29'b0, ifD.o_valid};
      default: return 32'hDEAD_0000;
    endcase
  endfunction

  task automatic checkOutput(input chk_t c);
    logic [31:0] act;
    act = actual(c.sel);
    nChecks++;
    if (act !== c.exp) begin
      nFails++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", selName[c.sel], cycle, act, c.exp);
    end
  endtask

  // Scoreboard drain: one time unit after each rising edge, compare every entry due now.
  always begin
    @(posedge clk);
    #1;
    cycle++;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cycle) begin
        checkOutput(sbq[i]);
        sbq.delete(i);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rstAbc = v.rst;
    ifA.i_we = v.we;  ifA.i_wBe = v.be;  ifA.i_wAddr = v.wa;  ifA.i_dataIn = v.wd;
    ifA.i_rEn = v.ren; ifA.i_rAddr = {v.ra1, v.ra0};
    ifB.i_we = v.we;  ifB.i_wBe = v.be;  ifB.i_wAddr = v.wa;  ifB.i_dataIn = v.wd;
    ifB.i_rEn = v.ren; ifB.i_rAddr = {v.ra1, v.ra0};
    ifC.i_we = v.we;  ifC.i_wBe = v.be;  ifC.i_wAddr = v.wa;  ifC.i_dataIn = v.wd;
    ifC.i_rEn = v.ren; ifC.i_rAddr = {v.ra1, v.ra0};
    sbq.push_back('{cycle + 1, 0, v.a0});
    sbq.push_back('{cycle + 1, 1, v.a1});
    sbq.push_back('{cycle + 1, 2, {30'b0, v.vld}});
    sbq.push_back('{cycle + 1, 3, v.b0});
    sbq.push_back('{cycle + 1, 4, v.c0});
    sbq.push_back('{cycle + 1, 5, v.c1});
  endtask

  task automatic applyStimulusD(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [2:0] ren,
                                input logic [4:0] ra);
    @(negedge clk);
    rstD = rst;
    ifD.i_we = we;  ifD.i_wBe = 4'hF;  ifD.i_wAddr = wa;  ifD.i_dataIn = wd;
    ifD.i_rEn = ren; ifD.i_rAddr = {ra, ra, ra};
  endtask

  task automatic expectD(input int lat, input logic [31:0] q, input logic [2:0] vld);
    sbq.push_back('{cycle + lat, 6, q});
    sbq.push_back('{cycle + lat, 7, q});
    sbq.push_back('{cycle + lat, 8, q});
    sbq.push_back('{cycle + lat, 9, {29'b0, vld}});
  endtask

  // Main sequence: shared vector table first, then the pipelined-port scenarios.
  initial begin
    rstAbc = 1'b1;
    rstD   = 1'b1;
    ifA.i_we = 1'b0; ifA.i_wBe = '0; ifA.i_wAddr = '0; ifA.i_dataIn = '0; ifA.i_rEn = '0; ifA.i_rAddr = '0;
    ifB.i_we = 1'b0; ifB.i_wBe = '0; ifB.i_wAddr = '0; ifB.i_dataIn = '0; ifB.i_rEn = '0; ifB.i_rAddr = '0;
    ifC.i_we = 1'b0; ifC.i_wBe = '0; ifC.i_wAddr = '0; ifC.i_dataIn = '0; ifC.i_rEn = '0; ifC.i_rAddr = '0;
    ifD.i_we = 1'b0; ifD.i_wBe = '0; ifD.i_wAddr = '0; ifD.i_dataIn = '0; ifD.i_rEn = '0; ifD.i_rAddr = '0;

    //           rst   we    be     wa      wd             ren    ra0    ra1    vld    a0             a1             b0             c0             c1
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 5'd31, 32'hFFFF_FFFF, 2'b11, 5'd0,  5'd31, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 5'd31, 32'hFFFF_FFFF, 2'b11, 5'd0,  5'd31, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b11, 5'd0,  5'd31, 2'b11, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 5'd5,  32'h1122_3344, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h5, 5'd5,  32'hAABB_CCDD, 2'b01, 5'd5,  5'd0,  2'b01, 32'h11BB_33DD, 32'h0,         32'h1122_3344, 32'h11BB_33DD, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b11, 5'd5,  5'd5,  2'b11, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 5'd7,  32'hCAFE_BABE, 2'b01, 5'd7,  5'd7,  2'b01, 32'hCAFE_BABE, 32'h11BB_33DD, 32'h0,         32'hCAFE_BABE, 32'h11BB_33DD};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b11, 5'd7,  5'd7,  2'b11, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 5'd3,  32'h0000_0003, 2'b00, 5'd0,  5'd0,  2'b00, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 5'd0,  32'hDEAD_BEEF, 2'b11, 5'd0,  5'd3,  2'b11, 32'hDEAD_BEEF, 32'h3,         32'h0,         32'h0,         32'h3};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b11, 5'd0,  5'd0,  2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 5'd3,  32'hFFFF_FFFF, 2'b10, 5'd0,  5'd3,  2'b10, 32'hDEAD_BEEF, 32'h3,         32'hDEAD_BEEF, 32'h0,         32'h3};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b11, 5'd3,  5'd31, 2'b11, 32'h3,         32'h0,         32'h3,         32'h3,         32'h0};
    vecs[13] = '{1'b1, 1'b1, 4'hF, 5'd5,  32'h0,         2'b11, 5'd0,  5'd0,  2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         2'b01, 5'd5,  5'd0,  2'b01, 32'h11BB_33DD, 32'h0,         32'h11BB_33DD, 32'h11BB_33DD, 32'h0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
    end

    // Pipelined 3-port variant: preload, back-to-back reads, then drop enable.
    applyStimulusD(1'b0, 1'b1, 5'd1, 32'h0000_0101, 3'b000, 5'd0);
    applyStimulusD(1'b0, 1'b1, 5'd2, 32'h0000_0202, 3'b000, 5'd0);
    applyStimulusD(1'b0, 1'b1, 5'd3, 32'h0000_0303, 3'b000, 5'd0);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b111, 5'd1);
    expectD(1, 32'h0, 3'b000);
    expectD(2, 32'h0000_0101, 3'b111);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b111, 5'd2);
    expectD(2, 32'h0000_0202, 3'b111);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b111, 5'd3);
    expectD(2, 32'h0000_0303, 3'b111);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b000, 5'd0);
    expectD(2, 32'h0000_0303, 3'b000);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b000, 5'd0);
    expectD(2, 32'h0000_0303, 3'b000);

    // Mid-operation reset with a read in flight: the result must never surface.
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b111, 5'd2);
    expectD(1, 32'h0000_0303, 3'b000);
    applyStimulusD(1'b1, 1'b0, 5'd0, 32'h0,         3'b000, 5'd0);
    expectD(1, 32'h0, 3'b000);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b000, 5'd0);
    expectD(1, 32'h0, 3'b000);
    applyStimulusD(1'b0, 1'b0, 5'd0, 32'h0,         3'b000, 5'd0);
    expectD(1, 32'h0, 3'b000);

    repeat (4) @(negedge clk);

    foreach (sbq[i]) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s never checked: due cycle %0d expected %h", selName[sbq[i].sel], sbq[i].due, sbq[i].exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
